alu_initiator: RTL and testbench
================================

ALU_INITIATOR -- requirements
Module: alu_initiator

Interface
REQ-001 Parameter SETTLE, default 2, meaning ALU evaluation wait in clock cycles (legal 1..15).
REQ-002 Parameter DATA_W, default 16, meaning operand/result width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req_valid  input  1  host presents an operation.
REQ-006 req_ready  output  1  block can accept an operation.
REQ-007 req_op  input  2  opcode: 00 AND, 01 NOT b, 10 ADD, 11 SAT (per-byte saturating add).
REQ-008 req_ra, req_rb, req_rd  input  2 each  source A, source B and destination register indices.
REQ-009 wr_en, wr_addr[1:0], wr_data[DATA_W-1:0]  input  host register preload port.
REQ-010 alu_a, alu_b  output  DATA_W each  operands driven to the ALU.
REQ-011 alu_s  output  2  ALU select, equal to the captured opcode.
REQ-012 alu_out  input  DATA_W  ALU result.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  host accepts result.
REQ-015 rsp_data  output  DATA_W  result value; rsp_rd  output  2  destination index.

Function
REQ-016 The block SHALL contain a 4 x DATA_W register file and a state machine with states IDLE, EXEC, RSP.
REQ-017 req_ready SHALL be 1 only in IDLE; acceptance is req_valid&req_ready at a rising edge.
REQ-018 On acceptance, the block SHALL capture op, rd, and operands regfile[ra], regfile[rb] into operand registers, load the settle counter with SETTLE-1, and enter EXEC.
REQ-019 If wr_en targets ra or rb in the acceptance cycle, the captured operand SHALL be wr_data (bypass).
REQ-020 alu_a, alu_b, alu_s SHALL come directly from the operand registers and stay stable from acceptance until return to IDLE.
REQ-021 EXEC SHALL last exactly SETTLE cycles; in the last EXEC cycle (counter 0) alu_out SHALL be captured into rsp_data and written to regfile[rd], and the state SHALL move to RSP.
REQ-022 If a wr_en write hits the same address as the EXEC write-back in the same cycle, the write-back SHALL win.
REQ-023 If acceptance occurs at edge N, rsp_valid SHALL first be 1 after edge N+SETTLE.
REQ-024 rsp_valid SHALL be 1 throughout RSP, and rsp_data/rsp_rd SHALL hold stable until rsp_valid&rsp_ready.
REQ-025 On rsp_valid&rsp_ready the block SHALL return to IDLE; the next acceptance is possible one cycle later (no overlap).
REQ-026 wr_en writes SHALL take effect in any state; req_valid outside IDLE SHALL be ignored.

Reset
REQ-027 While rst is 1, the state SHALL be IDLE, all regfile entries 0, and operand registers and counter 0.
REQ-028 While rst is 1, outputs SHALL be req_ready 0, rsp_valid 0, rsp_data 0, rsp_rd 0, and alu_a/alu_b/alu_s 0.
REQ-029 req_ready SHALL be 1 from the first edge after rst falls.
REQ-030 Reset asserted in EXEC or RSP SHALL abort the operation with no write-back and no response.

Structure
REQ-031 Shared package alu_pkg SHALL hold the opcode constants (OP_AND, OP_NOT, OP_ADD, OP_SAT), the state encoding, and the default data width.
REQ-032 The register file SHALL be a sub-module, alu_regfile, with two combinational read ports, the host write port, and the write-back port with write-back priority.
REQ-033 The ALU itself SHALL be external; the bench SHALL connect a behavioural ALU model.

Verification
REQ-034 Preload r0=0x0102, r1=0x0304; issue ADD ra=0 rb=1 rd=2 with SETTLE=2 -> rsp_valid after acceptance edge+2, rsp_data=0x0406, r2=0x0406.
REQ-035 Preload r0=0x7F01, r1=0x0101; issue SAT -> rsp_data=0x7F02; preload r0=0xF0F0, r1=0x0FF0; issue AND -> 0x00F0; issue NOT with rb=0x00FF -> 0xFF00.
REQ-036 Hold rsp_ready=0 for 3 cycles in RSP -> rsp_valid stays 1, rsp_data is unchanged, req_ready stays 0, and a req_valid is ignored.
REQ-037 Drive wr_en to ra=1 with 0x1111 in the acceptance cycle -> alu_a=0x1111; drive wr_en to rd in the last EXEC cycle -> regfile holds the ALU result.
REQ-038 Assert rst in the second EXEC cycle -> rsp_valid is never asserted, regfile is all 0, and req_ready is 1 after reset release.
REQ-039 Back-to-back: rd of op1 used as ra of op2 -> op2 sees op1's result; SETTLE=1 and SETTLE=15 give latency 1 and 15.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and captured-command layout for the ALU initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_NOT = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SAT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] rd;
    } cmd_t;

endpackage

// File: rtl/alu_regfile.sv
// 4-entry register file: two combinational read ports, host write port and ALU write-back port.
// Latency: reads are combinational and see a same-cycle host write; writes land on the next edge.
// Backpressure: none; write-back beats a host write to the same address.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rd_addr_a,
    input  logic [1:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wb_en,
    input  logic [1:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] regs [4];
    logic              host_wr_ok;

    assign host_wr_ok = wr_en && !(wb_en && (wb_addr == wr_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (host_wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

    // Host write is forwarded so an operation accepted in the same cycle sees the new value.
    assign rd_data_a = (wr_en && (wr_addr == rd_addr_a)) ? wr_data : regs[rd_addr_a];
    assign rd_data_b = (wr_en && (wr_addr == rd_addr_b)) ? wr_data : regs[rd_addr_b];

endmodule

// File: rtl/alu_initiator.sv
// Issues register-file operands to an external ALU, waits SETTLE cycles, writes back and responds.
// Latency: rsp_valid rises SETTLE cycles after acceptance; next acceptance one cycle after the response handshake.
// Backpressure: one operation in flight; req_ready low outside IDLE, response held until rsp_ready.
module alu_initiator
    import alu_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [1:0]        req_ra,
    input  logic [1:0]        req_rb,
    input  logic [1:0]        req_rd,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_s,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_rd
);

    // SETTLE is legal in 1..15, so a 4-bit down-counter covers the full range.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    cmd_t              cmd_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              live;
    logic              accept;
    logic              wb_en;
    logic [DATA_W-1:0] rf_a, rf_b;

    alu_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (req_ra),
        .rd_addr_b (req_rb),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wb_en     (wb_en),
        .wb_addr   (cmd_q.rd),
        .wb_data   (alu_out)
    );

    // live keeps req_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wb_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid && live) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == 4'd0) begin
                    wb_en     = 1'b1;
                    state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 4'd0;
            cmd_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                cnt      <= CNT_LOAD;
                cmd_q.op <= req_op;
                cmd_q.rd <= req_rd;
                opa_q    <= rf_a;
                opb_q    <= rf_b;
            end else if ((state == ST_EXEC) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (wb_en) begin
                rsp_data_q <= alu_out;
            end
        end
    end

    assign req_ready = (state == ST_IDLE) && live;
    assign rsp_valid = (state == ST_RSP);
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = cmd_q.rd;
    assign alu_a     = opa_q;
    assign alu_b     = opb_q;
    assign alu_s     = cmd_q.op;

endmodule

// File: tb/tb_alu_initiator.sv
// Bench for alu_initiator: three instances (SETTLE 2, 1, 15) sharing the register preload port,
// each driving its own behavioural ALU; results are scoreboarded against a register model.
`timescale 1ns/1ps
module tb_alu_initiator;
    import alu_pkg::*;

    localparam int DW = 16;
    localparam int N  = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    rd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0]    req_op, req_ra, req_rb, req_rd;
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] alu_a [N];
    logic [DW-1:0] alu_b [N];
    logic [DW-1:0] alu_out [N];
    logic [DW-1:0] rsp_data [N];
    logic [1:0]    alu_s [N];
    logic [1:0]    rsp_rd [N];

    logic [DW-1:0] mrf [N][4];
    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;

    function automatic logic [DW-1:0] alu_f(input logic [1:0] s, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW-1:0]     r;
        logic signed [8:0] sum;
        r = '0;
        case (s)
            OP_AND: r = a & b;
            OP_NOT: r = ~b;
            OP_ADD: r = a + b;
            default: begin
                for (int i = 0; i < DW / 8; i++) begin
                    sum = $signed({a[8*i+7], a[8*i+:8]}) + $signed({b[8*i+7], b[8*i+:8]});
                    if (sum > 9'sd127)       r[8*i+:8] = 8'h7F;
                    else if (sum < -9'sd128) r[8*i+:8] = 8'h80;
                    else                     r[8*i+:8] = sum[7:0];
                end
            end
        endcase
        return r;
    endfunction

    function automatic int settle_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_alu
        assign alu_out[g] = alu_f(alu_s[g], alu_a[g], alu_b[g]);
    end

    alu_initiator #(.SETTLE(2), .DATA_W(DW)) u_s2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op), .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_s(alu_s[0]), .alu_out(alu_out[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_rd(rsp_rd[0])
    );

    alu_initiator #(.SETTLE(1), .DATA_W(DW)) u_s1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op), .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_s(alu_s[1]), .alu_out(alu_out[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_rd(rsp_rd[1])
    );

    alu_initiator #(.SETTLE(15), .DATA_W(DW)) u_s15 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_op(req_op), .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_s(alu_s[2]), .alu_out(alu_out[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_data(rsp_data[2]), .rsp_rd(rsp_rd[2])
    );

    task automatic host_write(input logic [1:0] addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        for (int j = 0; j < N; j++) mrf[j][addr] = data;
    endtask

    // Issues one operation on instance k and checks operands, latency and response.
    // hold: cycles to stall the response while presenting a request that must be ignored.
    // byp: host write issued in the acceptance cycle; clash: host write to rd in the last EXEC cycle.
    task automatic do_op(input int k, input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd, input int hold,
                         input bit byp, input logic [1:0] byp_addr, input logic [DW-1:0] byp_data,
                         input bit clash, input logic [DW-1:0] clash_data,
                         output logic [DW-1:0] got);
        logic [DW-1:0] ea, eb;
        exp_t          e, e2;
        int            lat, wait_cnt;
        bit            unstable;
        ea = mrf[k][ra];
        eb = mrf[k][rb];
        if (byp) begin
            if (byp_addr == ra) ea = byp_data;
            if (byp_addr == rb) eb = byp_data;
        end
        e.data = alu_f(op, ea, eb);
        e.rd   = rd;
        sb.push_back(e);
        req_op = op; req_ra = ra; req_rb = rb; req_rd = rd;
        req_valid[k] = 1'b1;
        if (byp) begin
            wr_en = 1'b1; wr_addr = byp_addr; wr_data = byp_data;
        end
        wait_cnt = 0;
        while (req_ready[k] !== 1'b1 && wait_cnt < 50) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        checks++;
        if (wait_cnt >= 50) begin
            failures++;
            $display("FAIL accept_timeout inst=%0d req_ready=%b required=1", k, req_ready[k]);
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        wr_en = 1'b0;
        if (byp) for (int j = 0; j < N; j++) mrf[j][byp_addr] = byp_data;
        checks++;
        if (alu_a[k] !== ea || alu_b[k] !== eb || alu_s[k] !== op) begin
            failures++;
            $display("FAIL alu_operands inst=%0d got a=%h b=%h s=%0d required a=%h b=%h s=%0d",
                     k, alu_a[k], alu_b[k], alu_s[k], ea, eb, op);
        end
        lat = 0;
        unstable = 1'b0;
        while (rsp_valid[k] !== 1'b1 && lat < 40) begin
            if (clash && lat == settle_of(k) - 1) begin
                wr_en = 1'b1; wr_addr = rd; wr_data = clash_data;
            end
            if (alu_a[k] !== ea || alu_b[k] !== eb || alu_s[k] !== op) unstable = 1'b1;
            @(posedge clk); #1;
            wr_en = 1'b0;
            lat++;
        end
        if (clash) for (int j = 0; j < N; j++) mrf[j][rd] = clash_data;
        mrf[k][rd] = e.data;
        checks++;
        if (unstable) begin
            failures++;
            $display("FAIL alu_stable inst=%0d operands changed during EXEC", k);
        end
        checks++;
        if (lat != settle_of(k)) begin
            failures++;
            $display("FAIL latency inst=%0d got=%0d required=%0d", k, lat, settle_of(k));
        end
        for (int h = 0; h < hold; h++) begin
            req_valid[k] = 1'b1;
            req_op = op ^ 2'b01; req_ra = ra + 2'd1; req_rb = rb + 2'd1; req_rd = rd + 2'd1;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[k] !== 1'b1 || rsp_data[k] !== e.data || req_ready[k] !== 1'b0 || alu_s[k] !== op) begin
                failures++;
                $display("FAIL rsp_hold inst=%0d cyc=%0d got vld=%b dat=%h rdy=%b s=%0d required vld=1 dat=%h rdy=0 s=%0d",
                         k, h, rsp_valid[k], rsp_data[k], req_ready[k], alu_s[k], e.data, op);
            end
        end
        req_valid[k] = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty inst=%0d", k);
            got = rsp_data[k];
        end else begin
            e2 = sb.pop_front();
            got = rsp_data[k];
            if (rsp_valid[k] !== 1'b1 || rsp_data[k] !== e2.data || rsp_rd[k] !== e2.rd) begin
                failures++;
                $display("FAIL rsp inst=%0d got vld=%b dat=%h rd=%0d required vld=1 dat=%h rd=%0d",
                         k, rsp_valid[k], rsp_data[k], rsp_rd[k], e2.data, e2.rd);
            end
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        checks++;
        if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
            failures++;
            $display("FAIL rsp_release inst=%0d got vld=%b rdy=%b required vld=0 rdy=1",
                     k, rsp_valid[k], req_ready[k]);
        end
    endtask

    task automatic op0(input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, output logic [DW-1:0] got);
        do_op(0, op, ra, rb, rd, 0, 1'b0, 2'd0, '0, 1'b0, '0, got);
    endtask

    task automatic expect_val(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (req_ready !== 3'b000 || rsp_valid !== 3'b000 || rsp_data[0] !== '0 || rsp_rd[0] !== 2'd0 ||
            alu_a[0] !== '0 || alu_b[0] !== '0 || alu_s[0] !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b dat=%h rd=%0d a=%h b=%h s=%0d required all 0",
                     req_ready, rsp_valid, rsp_data[0], rsp_rd[0], alu_a[0], alu_b[0], alu_s[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready_held got=%b required=000", req_ready);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 3'b111 || rsp_valid !== 3'b000) begin
            failures++;
            $display("FAIL ready_after_reset got rdy=%b vld=%b required rdy=111 vld=000", req_ready, rsp_valid);
        end
        for (int j = 0; j < N; j++) for (int r = 0; r < 4; r++) mrf[j][r] = '0;
    endtask

    task automatic test_add();
        logic [DW-1:0] got;
        host_write(2'd0, 16'h0102);
        host_write(2'd1, 16'h0304);
        op0(OP_ADD, 2'd0, 2'd1, 2'd2, got);
        expect_val("add_result", got, 16'h0406);
        op0(OP_AND, 2'd2, 2'd2, 2'd2, got);
        expect_val("add_writeback_r2", got, 16'h0406);
    endtask

    task automatic test_ops();
        logic [DW-1:0] got;
        host_write(2'd0, 16'h7F01);
        host_write(2'd1, 16'h0101);
        op0(OP_SAT, 2'd0, 2'd1, 2'd3, got);
        expect_val("sat_result", got, 16'h7F02);
        host_write(2'd0, 16'h80F0);
        host_write(2'd1, 16'h8020);
        op0(OP_SAT, 2'd0, 2'd1, 2'd3, got);
        expect_val("sat_negative", got, 16'h8010);
        host_write(2'd0, 16'hF0F0);
        host_write(2'd1, 16'h0FF0);
        op0(OP_AND, 2'd0, 2'd1, 2'd3, got);
        expect_val("and_result", got, 16'h00F0);
        host_write(2'd1, 16'h00FF);
        op0(OP_NOT, 2'd0, 2'd1, 2'd3, got);
        expect_val("not_result", got, 16'hFF00);
    endtask

    task automatic test_rsp_hold();
        logic [DW-1:0] got;
        host_write(2'd0, 16'h00AA);
        host_write(2'd1, 16'h0F0F);
        do_op(0, OP_AND, 2'd0, 2'd1, 2'd1, 3, 1'b0, 2'd0, '0, 1'b0, '0, got);
        expect_val("hold_result", got, 16'h000A);
        @(posedge clk); #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || alu_s[0] !== OP_AND) begin
            failures++;
            $display("FAIL ignored_req got vld=%b s=%0d required vld=0 s=%0d", rsp_valid[0], alu_s[0], OP_AND);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] got;
        host_write(2'd0, 16'h0002);
        host_write(2'd1, 16'h0001);
        do_op(0, OP_ADD, 2'd1, 2'd0, 2'd3, 0, 1'b1, 2'd1, 16'h1111, 1'b0, '0, got);
        expect_val("bypass_result", got, 16'h1113);
        do_op(0, OP_ADD, 2'd0, 2'd1, 2'd2, 0, 1'b0, 2'd0, '0, 1'b1, 16'hDEAD, got);
        expect_val("clash_result", got, 16'h1113);
        op0(OP_AND, 2'd2, 2'd2, 2'd2, got);
        expect_val("clash_writeback_wins", got, 16'h1113);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] got;
        bit            seen;
        host_write(2'd0, 16'h1234);
        host_write(2'd1, 16'h0001);
        req_op = OP_ADD; req_ra = 2'd0; req_rb = 2'd1; req_rd = 2'd2;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0 || alu_a[0] !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got vld=%b rdy=%b a=%h required 0 0 0",
                     rsp_valid[0], req_ready[0], alu_a[0]);
        end
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b0;
        for (int j = 0; j < N; j++) for (int r = 0; r < 4; r++) mrf[j][r] = '0;
        @(posedge clk); #1;
        checks++;
        if (req_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_ready got=%b required=1", req_ready[0]);
        end
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid[0] !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL mid_reset_no_rsp rsp_valid seen=1 required=0");
        end
        for (int r = 0; r < 4; r++) begin
            op0(OP_AND, 2'(r), 2'(r), 2'(r), got);
            expect_val("mid_reset_rf_zero", got, 16'h0000);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got;
        host_write(2'd0, 16'h0010);
        host_write(2'd1, 16'h0020);
        op0(OP_ADD, 2'd0, 2'd1, 2'd3, got);
        expect_val("b2b_op1", got, 16'h0030);
        checks++;
        if (req_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready got=%b required=1", req_ready[0]);
        end
        op0(OP_ADD, 2'd3, 2'd0, 2'd2, got);
        expect_val("b2b_op2", got, 16'h0040);
    endtask

    task automatic test_settle();
        logic [DW-1:0] got;
        host_write(2'd0, 16'h0100);
        host_write(2'd1, 16'h0023);
        do_op(1, OP_ADD, 2'd0, 2'd1, 2'd2, 0, 1'b0, 2'd0, '0, 1'b0, '0, got);
        expect_val("settle1_result", got, 16'h0123);
        do_op(2, OP_NOT, 2'd0, 2'd1, 2'd3, 0, 1'b0, 2'd0, '0, 1'b0, '0, got);
        expect_val("settle15_result", got, 16'hFFDC);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; rsp_ready = '0;
        req_op = 2'd0; req_ra = 2'd0; req_rb = 2'd0; req_rd = 2'd0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0;
        test_reset();
        test_add();
        test_ops();
        test_rsp_hold();
        test_bypass();
        test_back_to_back();
        test_settle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
